// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for the bit-serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, overflow, zero
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B (A + ~B + 1), LSB first, one full-adder cell
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rstn,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic             live_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             in_ready;
    logic             out_valid;
    logic             accept;
    logic             last;
    logic             nb;
    logic             s;
    logic             cout;
    logic [WIDTH-1:0] res_shift;

    assign accept    = bus.in_valid && in_ready;
    assign last      = (cnt_q == CW'(WIDTH - 1));
    assign nb        = ~b_q[0];
    assign s         = a_q[0] ^ nb ^ carry_q;
    assign cout      = (a_q[0] & nb) | (a_q[0] & carry_q) | (nb & carry_q);
    assign res_shift = {s, res_q[WIDTH-1:1]};

    // live_q keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = live_q && (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        if (state_q == IDLE && accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            res_d   = '0;
            carry_d = 1'b1;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            res_d   = res_shift;
            carry_d = cout;
            cnt_d   = cnt_q + CW'(1);
            // on the MSB step carry_q is the carry into the sign bit
            if (last) begin
                diff_d   = res_shift;
                borrow_d = ~cout;
                ovf_d    = carry_q ^ cout;
                zero_d   = (res_shift == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor: accepts two WIDTH-bit operands over a valid/ready handshake and computes D = A − B one bit per clock, LSB first, through a single internal full-adder cell with a registered carry/borrow. It is the subtraction counterpart to the team's adder cell and sits in the arithmetic datapath wherever area matters more than latency. Results are returned over a second valid/ready handshake together with borrow, signed-overflow and zero flags.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- rstn  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands A, B present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend (unsigned or two's complement).
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (A − B) mod 2^WIDTH.
- borrow  output  1  1 when A < B as unsigned.
- overflow  output  1  1 when the signed result is not representable in WIDTH bits.
- zero  output  1  1 when diff == 0.

## Operation
- Reset (rstn = 0, asynchronous): state = IDLE, bit counter = 0, carry = 0, operand/result shift registers = 0. in_ready = 0 while rstn is low and 1 from the first clock edge after rstn is released. out_valid = 0, diff = 0, borrow = 0, overflow = 0, zero = 0. Reset asserted mid-operation aborts the operation; no partial result is ever presented.
- FSM states:
  - IDLE: in_ready = 1. On in_valid && in_ready, latch a and b, set carry = 1 (the +1 of A + ~B + 1), set counter = 0, go to RUN.
  - RUN: in_ready = 0. Each cycle computes s = a[i] ^ ~b[i] ^ carry and carry' = majority(a[i], ~b[i], carry), then shifts s into the result MSB and shifts the operand registers right. Just before the MSB step, the carry into the MSB is saved. After the step with counter = WIDTH−1, go to DONE.
  - DONE: out_valid = 1. The outputs are registered:
    - borrow = ~final carry.
    - overflow = carry into MSB XOR final carry.
    - zero = (diff == 0).
    - On out_valid && out_ready, go to IDLE.
- While in RUN or DONE, in_valid is ignored and no operands are captured.
- diff and the flags are held stable for the whole time out_valid is high. They keep their last values after returning to IDLE, but are meaningful only while out_valid = 1.
- Signed and unsigned interpretations share the same diff; the consumer chooses which flag to use.

## Timing
- Acceptance edge T0: in_valid && in_ready are sampled high.
- Bit i is processed on edge T(i+1). out_valid rises after edge T(WIDTH) and is visible in the cycle following that edge. Latency from acceptance to out_valid is WIDTH cycles.
- Result handshake completes on edge Tr (out_valid && out_ready). in_ready is 1 in the next cycle; there is no same-cycle bypass. Minimum initiation interval is WIDTH + 2 cycles when out_ready is held at 1.
- out_ready may be high before out_valid rises. The transfer then occurs on the first edge where out_valid = 1, and out_valid stays high for exactly one cycle.
- Back-pressure: out_valid stays high and the outputs stay constant for any number of cycles with out_ready = 0.
- in_ready does not depend combinationally on any input. out_valid does not depend combinationally on out_ready.

## Test plan
- Basic: WIDTH = 8, a = 0x35, b = 0x12 → after 8 cycles, out_valid with diff = 0x23, borrow = 0, overflow = 0, zero = 0.
- Underflow and zero: a = 0x00, b = 0x01 → diff = 0xFF, borrow = 1, overflow = 0. Then a = 0x5A, b = 0x5A → diff = 0x00, zero = 1, borrow = 0.
- Signed overflow: a = 0x80, b = 0x01 → diff = 0x7F, overflow = 1, borrow = 0. Then a = 0x7F, b = 0xFF → diff = 0x80, overflow = 1, borrow = 1.
- Back-pressure and busy: hold out_ready = 0 for 5 cycles after out_valid, and pulse in_valid with new operands during RUN and DONE → outputs stay constant, in_ready = 0, and the new operands are not captured; the first result then transfers, and in_ready = 1 on the next cycle.
- Back-to-back: out_ready = 1 and in_valid held high with 4 operand pairs → 4 correct results spaced exactly WIDTH + 2 cycles apart.
- Reset mid-RUN: drop rstn at bit 3 of an operation → out_valid = 0 and in_ready = 0 immediately. After release, in_ready = 1 on the next edge and a fresh 0x10 − 0x01 yields diff = 0x0F.
